fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem port,
// DEPTH-entry prefetch FIFO to decode, redirect flush and halt detection.
module fetch_unit #(
    parameter int              ADDR_W      = 16,
    parameter int              INSTR_W     = 16,
    parameter int              DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              PC_STEP     = 2,
    parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ack,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     out_valid,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    input  logic                     out_ready,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     hlt,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
    logic               push, pop;

    // The request is masked by redirect so a flushing cycle never completes a transfer.
    assign imem_req   = (state_q == FETCH) && (count_q != CNT_W'(DEPTH)) && !redirect;
    assign imem_addr  = fetch_pc_q;
    assign push       = imem_req && imem_ack;
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    assign out_instr  = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc     = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign hlt        = (state_q == HALTED);
    assign fifo_count = count_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            state_d    = FETCH;
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (state_q == IDLE) state_d = FETCH;
            if (push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                if (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE) state_d = HALTED;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        out_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        hlt;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        mq[$];
    bit          started, halted;
    logic [15:0] fpc;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .hlt(hlt), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h000A) ? 16'hF000 : (a ^ 16'hA500);
    endfunction

    function automatic bit model_req(input bit rd);
        return started && !halted && (mq.size() < 4) && !rd;
    endfunction

    function automatic void model_reset();
        mq.delete();
        started = 0;
        halted  = 0;
        fpc     = 16'h0000;
    endfunction

    // Called at a falling edge: drive inputs, check outputs, advance model at the rising edge.
    task automatic step(input bit rd, input logic [15:0] rpc, input bit rdy,
                        input bit ack, input bit rnd);
        bit req_e;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        imem_ack    = ack;
        imem_rdata  = rnd ? 16'($urandom) : mem_word(fpc);
        req_e       = model_req(rd);
        #1;
        chk("req",   32'(imem_req),  32'(req_e));
        chk("addr",  32'(imem_addr), 32'(fpc));
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("instr", 32'(out_instr), 32'(mq[0].instr));
            chk("pc",    32'(out_pc),    32'(mq[0].pc));
        end
        chk("hlt",   32'(hlt),        32'(halted));
        chk("count", 32'(fifo_count), 32'(mq.size()));
        @(posedge clk);
        if (rd) begin
            mq.delete();
            fpc     = rpc;
            started = 1;
            halted  = 0;
        end else begin
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (req_e && ack) begin
                mq.push_back({fpc, imem_rdata});
                if (imem_rdata[15:12] == 4'hF) halted = 1;
                fpc = fpc + 16'd2;
            end
            started = 1;
        end
        @(negedge clk);
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_req",   32'(imem_req),   32'd0);
        chk("rst_addr",  32'(imem_addr),  32'd0);
        chk("rst_valid", 32'(out_valid),  32'd0);
        chk("rst_instr", 32'(out_instr),  32'd0);
        chk("rst_pc",    32'(out_pc),     32'd0);
        chk("rst_hlt",   32'(hlt),        32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int wcnt;
        rst_n = 1'b0; redirect = 0; redirect_pc = 0; out_ready = 0;
        imem_ack = 0; imem_rdata = 0;
        model_reset();
        @(negedge clk);
        reset_checks();
        reset_release();

        // Backpressure: fill to DEPTH, then a single pop reopens the request
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_req",   32'(imem_req),   32'd0);
        chk("full_addr",  32'(imem_addr),  32'h0008);
        step(0, 0, 1, 1, 0);
        chk("reopen_req", 32'(imem_req), 32'd1);

        // Streaming
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0);

        // Variable latency: ack three cycles into each request
        step(1, 16'h0000, 1, 0, 0);
        wcnt = 0;
        for (int i = 0; i < 16; i++) begin
            bit a;
            a = model_req(0) && (wcnt == 3);
            step(0, 0, 1, a, 0);
            if (a) wcnt = 0;
            else if (started && !halted) wcnt++;
        end

        // Redirect colliding with a completing transfer and a dequeue
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 16'h0100, 1, 1, 0);
        chk("redir_count", 32'(fifo_count), 32'd0);
        chk("redir_addr",  32'(imem_addr),  32'h0100);
        step(0, 0, 0, 1, 0);
        chk("redir_pc",    32'(out_pc),     32'h0100);

        // Halt at 0x000A, drain, then restart via redirect
        step(1, 16'h000A, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("halt_hlt",   32'(hlt),       32'd1);
        chk("halt_pc",    32'(out_pc),    32'h000A);
        chk("halt_instr", 32'(out_instr), 32'hF000);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
        step(1, 16'h0020, 1, 1, 0);
        chk("resume_hlt",  32'(hlt),       32'd0);
        chk("resume_addr", 32'(imem_addr), 32'h0020);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);

        // Wrap, then asynchronous reset in the middle of a pending request
        step(1, 16'hFFFE, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("wrap_addr", 32'(imem_addr), 32'h0000);
        step(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",   32'(imem_req),   32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_valid", 32'(out_valid),  32'd0);
        model_reset();
        @(negedge clk);
        reset_checks();
        reset_release();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(15) == 0), 16'($urandom), ($urandom_range(9) < 6),
                 $urandom_range(1), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
